// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port, fixed-latency memory between instruction fetch (IF)
//   and load/store (MEM). Data accesses win arbitration unless fetch has been
//   passed over STARVE_LIMIT times in a row. Each access produces a one-cycle
//   ready pulse with registered read data; pipe_stall freezes the pipeline while
//   either stage is still waiting.
// Ports
//   CLK, RST                   clock (rising edge), asynchronous active-low reset
//   if_req/if_addr             fetch request and byte address
//   if_rdata/if_ready          fetched instruction and completion pulse
//   dm_read/dm_write           load / store request (store wins if both high)
//   dm_addr/dm_wdata           data address and store data
//   dm_rdata/dm_ready          load data and completion pulse
//   mem_en/mem_we              memory strobe (one cycle per access) and write enable
//   mem_addr/mem_wdata         registered memory address and write data
//   mem_rdata                  memory read data, valid MEM_LATENCY cycles after mem_en
//   pipe_stall                 combinational pipeline freeze
module unified_mem_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        pipe_stall
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        dsel_q, dsel_d;     // current grant belongs to the data port
  logic        store_q, store_d;   // current data access is a store
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        dm_req;

  assign dm_req = dm_read | dm_write;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    dsel_d     = dsel_q;
    store_d    = store_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (dm_req && !(if_req && starve_q == LIM)) begin
          state_d  = DATA;
          dsel_d   = 1'b1;
          store_d  = dm_write;
          addr_d   = dm_addr;
          wdata_d  = dm_wdata;
          mem_en_d = 1'b1;
          mem_we_d = dm_write;
          cnt_d    = LAT;
          // Count data grants that bypass a waiting fetch; saturate at the limit.
          if (!if_req)              starve_d = '0;
          else if (starve_q != LIM) starve_d = starve_q + 4'd1;
        end else if (if_req) begin
          state_d  = FETCH;
          dsel_d   = 1'b0;
          store_d  = 1'b0;
          addr_d   = if_addr;
          mem_en_d = 1'b1;
          cnt_d    = LAT;
          starve_d = '0;
        end
      end
      FETCH, DATA: begin
        if (cnt_q == '0) begin
          if (!dsel_q)       if_rdata_d = mem_rdata;
          else if (!store_q) dm_rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      dsel_q     <= 1'b0;
      store_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      dsel_q     <= dsel_d;
      store_q    <= store_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign if_ready   = (state_q == DONE) && !dsel_q;
  assign dm_ready   = (state_q == DONE) && dsel_q;
  assign pipe_stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vectors, expected grants and ready
// responses queued at issue time and checked by a separate monitor.
module tb_unified_mem_arbiter;

  localparam int L = 2;
  localparam int P = L + 3;  // cycles per access under continuous demand

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req, dm_read, dm_write;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_en, mem_we, pipe_stall;

  unified_mem_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: read data is valid only in the cycle L after mem_en.
  logic [31:0] mem [0:255];
  logic [31:0] rd_addr;
  int          dly;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'h8C01_0004;  // 0x10
      mem[16] <= 32'h1111_2222;  // 0x40
      dly     <= -1;
      rd_addr <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      rd_addr <= mem_addr;
      dly     <= L - 1;
    end else if (dly >= 0) begin
      dly <= dly - 1;
    end
  end
  assign mem_rdata = (dly == 0) ? mem[rd_addr[9:2]] : 32'hBAD0_BAD0;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  typedef struct { logic [31:0] addr; logic we; int cyc; } grant_t;
  exp_t   q_if[$];
  exp_t   q_dm[$];
  grant_t q_g[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_zero(input string name);
    chk({if_ready, dm_ready, mem_en, mem_we} == 4'b0, {name, "_flags"},
        {28'h0, if_ready, dm_ready, mem_en, mem_we}, 32'h0);
    chk((if_rdata | dm_rdata | mem_addr | mem_wdata) == 32'h0, {name, "_buses"},
        if_rdata | dm_rdata | mem_addr | mem_wdata, 32'h0);
  endtask

  // Monitor
  grant_t g;
  exp_t   e;
  always @(negedge CLK) begin
    if (RST) begin
      if (mem_we) chk(mem_en == 1'b1, "we_without_en", {31'h0, mem_en}, 32'h1);
      if (mem_en) begin
        if (q_g.size() == 0) chk(1'b0, "grant_unexpected", mem_addr, 32'h0);
        else begin
          g = q_g.pop_front();
          chk(mem_addr == g.addr, "grant_addr", mem_addr, g.addr);
          chk(mem_we == g.we, "grant_we", {31'h0, mem_we}, {31'h0, g.we});
          if (g.cyc >= 0) chk(cyc == g.cyc, "grant_cycle", cyc, g.cyc);
        end
      end
      if (if_ready && dm_ready) chk(1'b0, "both_ready", 32'h1, 32'h0);
      if (if_ready) begin
        if (q_if.size() == 0) chk(1'b0, "if_ready_unexpected", if_rdata, 32'h0);
        else begin
          e = q_if.pop_front();
          chk(if_rdata == e.data, "if_rdata", if_rdata, e.data);
          if (e.cyc >= 0) chk(cyc == e.cyc, "if_ready_cycle", cyc, e.cyc);
        end
      end
      if (dm_ready) begin
        if (q_dm.size() == 0) chk(1'b0, "dm_ready_unexpected", dm_rdata, 32'h0);
        else begin
          e = q_dm.pop_front();
          chk(dm_rdata == e.data, "dm_rdata", dm_rdata, e.data);
          if (e.cyc >= 0) chk(cyc == e.cyc, "dm_ready_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_ready_if(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge CLK);
      while (!if_ready && t < 200) begin @(negedge CLK); t++; end
      if (!if_ready) chk(1'b0, "if_timeout", 32'h0, 32'h1);
    end
    @(posedge CLK); #1;
    if_req = 1'b0;
  endtask

  task automatic wait_ready_dm(input int n, input bit chk_stall);
    int t;
    bit stall_ok = 1'b1;
    bit stall_at_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge CLK);
      while (!dm_ready && t < 200) begin
        if (!pipe_stall) stall_ok = 1'b0;
        @(negedge CLK); t++;
      end
      if (!dm_ready) chk(1'b0, "dm_timeout", 32'h0, 32'h1);
      stall_at_ready = pipe_stall;
    end
    @(posedge CLK); #1;
    dm_read = 1'b0; dm_write = 1'b0;
    if (chk_stall) begin
      chk(stall_ok, "stall_while_waiting", {31'h0, stall_ok}, 32'h1);
      chk(!stall_at_ready, "stall_at_ready", {31'h0, stall_at_ready}, 32'h0);
    end
  endtask

  task automatic dm_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
    int n;
    @(posedge CLK); #1;
    n = cyc;
    dm_read = rd; dm_write = wr; dm_addr = a; dm_wdata = wd;
    q_g.push_back('{a, wr, n + 1});
    q_dm.push_back('{exp_rd, n + L + 2});
    wait_ready_dm(1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    dm_read = 1'b1; dm_write = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h0;

    // Reset held with both requests pending
    repeat (3) begin @(negedge CLK); chk_zero("reset"); end
    n = cyc;
    RST = 1'b1;
    q_g.push_back('{32'h40, 1'b0, n + 1});
    q_dm.push_back('{32'h1111_2222, n + L + 2});
    q_g.push_back('{32'h10, 1'b0, n + L + 4});
    q_if.push_back('{32'h8C01_0004, n + 2 * L + 5});
    fork
      wait_ready_dm(1, 1'b0);
      wait_ready_if(1);
    join

    // Store then load; store with both strobes high keeps dm_rdata
    dm_access(1'b1, 1'b0, 32'h40, 32'h0,         32'h1111_2222);
    dm_access(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h1111_2222);
    dm_access(1'b1, 1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF);
    dm_access(1'b1, 1'b1, 32'h24, 32'h1234_5678, 32'hDEAD_BEEF);
    dm_access(1'b1, 1'b0, 32'h24, 32'h0,         32'h1234_5678);

    // Lone fetch
    @(posedge CLK); #1;
    n = cyc;
    if_req = 1'b1; if_addr = 32'h10;
    q_g.push_back('{32'h10, 1'b0, n + 1});
    q_if.push_back('{32'h8C01_0004, n + L + 2});
    wait_ready_if(1);

    // Contention: 4 data grants then 1 fetch, twice
    @(posedge CLK); #1;
    n = cyc;
    if_req = 1'b1; if_addr = 32'h10;
    dm_read = 1'b1; dm_write = 1'b0; dm_addr = 32'h40;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        q_g.push_back('{32'h10, 1'b0, n + P * k + 1});
        q_if.push_back('{32'h8C01_0004, n + P * k + L + 2});
      end else begin
        q_g.push_back('{32'h40, 1'b0, n + P * k + 1});
        q_dm.push_back('{32'h1111_2222, n + P * k + L + 2});
      end
    end
    fork
      wait_ready_dm(8, 1'b0);
      wait_ready_if(2);
    join

    // Reset during a data wait: access abandoned, restarts with full latency
    @(posedge CLK); #1;
    n = cyc;
    dm_read = 1'b1; dm_addr = 32'h40;
    q_g.push_back('{32'h40, 1'b0, n + 1});
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1 chk_zero("midreset_async");
    @(negedge CLK); chk_zero("midreset_hold");
    @(negedge CLK); chk_zero("midreset_hold2");
    n = cyc;
    RST = 1'b1;
    q_g.push_back('{32'h40, 1'b0, n + 1});
    q_dm.push_back('{32'h1111_2222, n + L + 2});
    wait_ready_dm(1, 1'b0);

    repeat (4) @(negedge CLK);
    chk(q_g.size() == 0, "grants_left", q_g.size(), 32'h0);
    chk(q_if.size() == 0, "if_left", q_if.size(), 32'h0);
    chk(q_dm.size() == 0, "dm_left", q_dm.size(), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
